// File: rtl/bcd_counter_nd_if.sv
// Bus bundle for the multi-digit BCD counter: control strobes, load value and status flags.
interface bcd_counter_nd_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  up_dn;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  ovf;
  logic                  load_err;

  modport master (
    output en, up_dn, load, load_val,
    input  count, tc, ovf, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, tc, ovf, load_err
  );
endinterface

// File: rtl/bcd_counter_nd.sv
// Parametrised multi-digit BCD up/down counter with parallel load, wrap or saturate
// at the terminals, a combinational cascade flag and registered overflow/load-error pulses.
module bcd_counter_nd #(
  parameter int DIGITS    = 2,
  parameter int MAX_COUNT = 99,
  parameter int SATURATE  = 0
) (
  input  logic            clk,
  input  logic            reset,
  bcd_counter_nd_if.slave bus
);
  localparam int W = 4 * DIGITS;

  // Decimal to packed BCD, evaluated only at elaboration to build the terminal constant.
  function automatic logic [31:0] toBcd(input int value);
    logic [31:0] r;
    int          v;
    r = '0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [31:0]  MAX_BCD_FULL = toBcd(MAX_COUNT);
  localparam logic [W-1:0] MAX_BCD      = MAX_BCD_FULL[W-1:0];

  logic [W-1:0] countReg;
  logic         ovfReg;
  logic         loadErrReg;
  logic [W-1:0] incVal;
  logic [W-1:0] decVal;
  logic         digitsOk;
  logic         loadOk;
  logic         atMax;
  logic         atZero;

  assign atMax  = (countReg == MAX_BCD);
  assign atZero = (countReg == '0);

  // Ripple the carry and borrow across all digits in one cycle; a 9 rolls to 0 going up, a 0 to 9 going down.
  always_comb begin
    logic carry;
    logic borrow;
    incVal = countReg;
    decVal = countReg;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (countReg[4*i +: 4] == 4'd9) begin
          incVal[4*i +: 4] = 4'd0;
        end else begin
          incVal[4*i +: 4] = countReg[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (countReg[4*i +: 4] == 4'd0) begin
          decVal[4*i +: 4] = 4'd9;
        end else begin
          decVal[4*i +: 4] = countReg[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // A load is accepted only if every nibble is a decimal digit and the whole word does not exceed the terminal.
  always_comb begin
    digitsOk = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) digitsOk = 1'b0;
    end
  end

  assign loadOk = digitsOk && (bus.load_val <= MAX_BCD);

  // Per-edge priority is load, then count, then hold; the flag pulses last exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      countReg   <= '0;
      ovfReg     <= 1'b0;
      loadErrReg <= 1'b0;
    end else if (bus.load) begin
      ovfReg <= 1'b0;
      if (loadOk) begin
        countReg   <= bus.load_val;
        loadErrReg <= 1'b0;
      end else begin
        loadErrReg <= 1'b1;
      end
    end else if (bus.en) begin
      loadErrReg <= 1'b0;
      if (bus.up_dn) begin
        if (atMax) begin
          ovfReg <= 1'b1;
          if (SATURATE == 0) countReg <= '0;
        end else begin
          ovfReg   <= 1'b0;
          countReg <= incVal;
        end
      end else begin
        if (atZero) begin
          ovfReg <= 1'b1;
          if (SATURATE == 0) countReg <= MAX_BCD;
        end else begin
          ovfReg   <= 1'b0;
          countReg <= decVal;
        end
      end
    end else begin
      ovfReg     <= 1'b0;
      loadErrReg <= 1'b0;
    end
  end

  assign bus.count    = countReg;
  assign bus.ovf      = ovfReg;
  assign bus.load_err = loadErrReg;
  assign bus.tc       = bus.en & ~bus.load & (bus.up_dn ? atMax : atZero);
endmodule
